// File: rtl/srdl2sv_widget_pkg.sv
// Shared types for the srdl2sv bus-widget register slice and the widgets that feed it.
package srdl2sv_widget_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } slice_fsm_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } OP_t;

    // Counter width able to hold 0..max; a zero max still yields a legal 1-bit vector.
    function automatic int unsigned cnt_bits(input int unsigned max);
        return (max == 0) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/srdl2sv_widget_if_slice_if.sv
// Request/response bundle used on both sides of the slice: the master drives requests, the slave answers.
interface srdl2sv_widget_if_slice_if #(
    parameter int BUS_BITS  = 32,
    parameter int ADDR_BITS = 32
);
    localparam int BUS_BYTES = BUS_BITS / 8;

    logic                 w_vld;
    logic                 r_vld;
    logic [ADDR_BITS-1:0] addr;
    logic [BUS_BITS-1:0]  w_data;
    logic [BUS_BYTES-1:0] byte_en;
    logic                 rdy;
    logic                 err;
    logic [BUS_BITS-1:0]  r_data;

    modport master (
        output w_vld, r_vld, addr, w_data, byte_en,
        input  rdy, err, r_data
    );

    modport slave (
        input  w_vld, r_vld, addr, w_data, byte_en,
        output rdy, err, r_data
    );

endinterface

// File: rtl/srdl2sv_timeout_cnt.sv
// Saturating wait counter; flags the last permitted cycle of an outstanding register access.
module srdl2sv_timeout_cnt
    import srdl2sv_widget_pkg::*;
#(
    parameter int unsigned MAX = 256
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = cnt_bits(MAX);

    logic [CW-1:0] cnt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(MAX)) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

    // Count starts at 0 on the first wait cycle, so MAX-1 marks the MAX-th cycle.
    assign expired = en && (cnt == CW'(MAX - 1));

endmodule

// File: rtl/srdl2sv_widget_if_slice.sv
// Register slice between a bus widget and srdl2sv register logic, with a watchdog that
// turns a register access that never answers into an error response.
module srdl2sv_widget_if_slice
    import srdl2sv_widget_pkg::*;
#(
    parameter int          BUS_BITS       = 32,
    parameter int          ADDR_BITS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    srdl2sv_widget_if_slice_if.slave   up,
    srdl2sv_widget_if_slice_if.master  dn
);
    localparam int BUS_BYTES = BUS_BITS / 8;

    slice_fsm_t state;
    slice_fsm_t state_nxt;

    OP_t                  op_p1;
    logic [ADDR_BITS-1:0] addr_p1;
    logic [BUS_BITS-1:0]  w_data_p1;
    logic [BUS_BYTES-1:0] byte_en_p1;
    logic                 err_p2;
    logic [BUS_BITS-1:0]  r_data_p2;

    logic accept;
    logic proto_err;
    logic expired;
    logic cnt_clr;
    logic cnt_en;

    // Writes never return data, whatever the register block leaves on its read bus.
    function automatic logic [BUS_BITS-1:0] read_only_data(input OP_t op, input logic [BUS_BITS-1:0] d);
        return (op == READ) ? d : '0;
    endfunction

    assign accept    = (state == S_IDLE) && (up.w_vld ^ up.r_vld);
    assign proto_err = (state == S_IDLE) && up.w_vld && up.r_vld;
    assign cnt_en    = (state == S_WAIT);
    assign cnt_clr   = (state == S_RESP);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            srdl2sv_timeout_cnt #(
                .MAX (TIMEOUT_CYCLES)
            ) u_timeout_cnt (
                .HCLK    (HCLK),
                .HRESETn (HRESETn),
                .clr     (cnt_clr),
                .en      (cnt_en),
                .expired (expired)
            );
        end else begin : g_no_wdog
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // dn_rdy is only honoured while waiting, so a late answer after a timeout falls away.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (proto_err) begin
                    state_nxt = S_RESP;
                end else if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dn.rdy || expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: request captured at acceptance, held stable towards the registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            op_p1      <= READ;
            addr_p1    <= '0;
            w_data_p1  <= '0;
            byte_en_p1 <= '0;
        end else if (accept) begin
            op_p1      <= up.w_vld ? WRITE : READ;
            addr_p1    <= up.addr;
            w_data_p1  <= up.w_data;
            byte_en_p1 <= up.byte_en;
        end
    end

    // Stage p2: response latched; dn_rdy takes priority over a coincident timeout.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_p2    <= 1'b0;
            r_data_p2 <= '0;
        end else if (proto_err) begin
            err_p2    <= 1'b1;
            r_data_p2 <= '0;
        end else if ((state == S_WAIT) && dn.rdy) begin
            err_p2    <= dn.err;
            r_data_p2 <= read_only_data(op_p1, dn.r_data);
        end else if ((state == S_WAIT) && expired) begin
            err_p2    <= 1'b1;
            r_data_p2 <= '0;
        end
    end

    always_comb begin
        up.rdy    = 1'b0;
        up.err    = 1'b0;
        up.r_data = '0;
        dn.w_vld  = 1'b0;
        dn.r_vld  = 1'b0;
        case (state)
            S_WAIT: begin
                dn.w_vld = (op_p1 == WRITE);
                dn.r_vld = (op_p1 == READ);
            end
            S_RESP: begin
                up.rdy    = 1'b1;
                up.err    = err_p2;
                up.r_data = r_data_p2;
            end
            default: ;
        endcase
    end

    assign dn.addr    = addr_p1;
    assign dn.w_data  = w_data_p1;
    assign dn.byte_en = byte_en_p1;

endmodule

// File: tb/tb_srdl2sv_widget_if_slice.sv
// Scoreboard bench for srdl2sv_widget_if_slice: directed corner cases then randomized traffic.
module tb_srdl2sv_widget_if_slice;
    localparam int BB = 32;
    localparam int AB = 32;
    localparam int TO = 8;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    srdl2sv_widget_if_slice_if #(.BUS_BITS(BB), .ADDR_BITS(AB)) up_if ();
    srdl2sv_widget_if_slice_if #(.BUS_BITS(BB), .ADDR_BITS(AB)) dn_if ();

    srdl2sv_widget_if_slice #(
        .BUS_BITS       (BB),
        .ADDR_BITS      (AB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .up      (up_if),
        .dn      (dn_if)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cycle;
    } up_exp_t;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dur;
    } dn_exp_t;

    up_exp_t up_q[$];
    dn_exp_t dn_q[$];

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    bit in_resp = 0;
    bit dn_skip = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream monitor: every up_rdy pulse must match the oldest expected response.
    initial begin
        bit prev_rdy;
        prev_rdy = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                prev_rdy = 0;
            end else begin
                if (up_if.rdy) begin
                    if (up_q.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL spurious_up_rdy: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        check("up_err", 64'(up_if.err), 64'(up_q[0].err));
                        check("up_r_data", 64'(up_if.r_data), 64'(up_q[0].data));
                        check("up_rdy_cycle", 64'(cyc), 64'(up_q[0].cycle));
                        void'(up_q.pop_front());
                    end
                end else if (prev_rdy) begin
                    check("up_err_after_rdy", 64'(up_if.err), 64'd0);
                    check("up_r_data_after_rdy", 64'(up_if.r_data), 64'd0);
                end
                prev_rdy = up_if.rdy;
            end
        end
    end

    // Downstream monitor: each dn access must carry the captured request for the expected time.
    initial begin
        bit      active;
        int      cnt;
        dn_exp_t de;
        active = 0;
        cnt    = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn || dn_skip) begin
                active = 0;
                cnt    = 0;
            end else if (dn_if.w_vld || dn_if.r_vld) begin
                if (dn_if.w_vld && dn_if.r_vld) begin
                    vectors++;
                    fails++;
                    $display("FAIL dn_both_vld: got w=1 r=1 expected one (cycle %0d)", cyc);
                end
                if (!active) begin
                    if (dn_q.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL spurious_dn_vld: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        de     = dn_q.pop_front();
                        active = 1;
                        cnt    = 0;
                    end
                end
                if (active) begin
                    cnt++;
                    check("dn_op", 64'(dn_if.w_vld), 64'(de.op));
                    check("dn_addr", 64'(dn_if.addr), 64'(de.addr));
                    check("dn_w_data", 64'(dn_if.w_data), 64'(de.wdata));
                    check("dn_byte_en", 64'(dn_if.byte_en), 64'(de.be));
                end
            end else if (active) begin
                check("dn_vld_cycles", 64'(cnt), 64'(de.dur));
                active = 0;
            end
        end
    end

    // kind: 0 read, 1 write, 2 both valids (protocol error). lat: wait cycle carrying dn_rdy.
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int lat, input logic derr,
                          input logic [31:0] drd, input int gap, input int stray);
        int w0;
        int rel;
        int ncyc;
        bit done;
        up_exp_t ue;
        dn_exp_t de;
        up_if.w_vld   = (kind != 0);
        up_if.r_vld   = (kind != 1);
        up_if.addr    = addr;
        up_if.w_data  = wdata;
        up_if.byte_en = be;
        dn_if.rdy     = 1'b0;
        w0 = cyc + (in_resp ? 2 : 1);
        if (kind == 2) begin
            ue = '{err: 1'b1, data: 32'h0, cycle: w0};
        end else begin
            de = '{op: (kind == 1), addr: addr, wdata: wdata, be: be,
                   dur: (lat < TO) ? lat + 1 : TO};
            dn_q.push_back(de);
            if (lat < TO)
                ue = '{err: derr, data: (kind == 0) ? drd : 32'h0, cycle: w0 + lat + 1};
            else
                ue = '{err: 1'b1, data: 32'h0, cycle: w0 + TO};
        end
        up_q.push_back(ue);
        done = 0;
        ncyc = 0;
        while (!done && ncyc < 40) begin
            @(posedge HCLK);
            #1;
            ncyc++;
            rel = cyc - w0;
            if (rel >= 0) begin
                up_if.addr    = $urandom;
                up_if.w_data  = $urandom;
                up_if.byte_en = 4'($urandom);
            end
            if (kind != 2 && rel == lat) begin
                dn_if.rdy    = 1'b1;
                dn_if.err    = derr;
                dn_if.r_data = drd;
            end else begin
                dn_if.rdy    = 1'b0;
                dn_if.err    = 1'($urandom);
                dn_if.r_data = $urandom;
            end
            if (up_if.rdy && rel >= 0) done = 1;
        end
        if (!done) begin
            vectors++;
            fails++;
            $display("FAIL txn_complete: got no up_rdy expected one within 40 cycles (cycle %0d)", cyc);
        end
        if (gap == 0) begin
            in_resp = 1;
        end else begin
            up_if.w_vld = 1'b0;
            up_if.r_vld = 1'b0;
            dn_if.rdy   = 1'b0;
            for (int g = 1; g <= gap; g++) begin
                @(posedge HCLK);
                #1;
                dn_if.rdy    = (g == stray);
                dn_if.err    = 1'($urandom);
                dn_if.r_data = $urandom;
            end
            in_resp = 0;
        end
    endtask

    task automatic reset_mid_access();
        dn_skip       = 1;
        up_if.w_vld   = 1'b0;
        up_if.r_vld   = 1'b1;
        up_if.addr    = 32'h70;
        dn_if.rdy     = 1'b0;
        @(posedge HCLK);
        #1;
        check("rst_pre_dn_r_vld", 64'(dn_if.r_vld), 64'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_dn_r_vld", 64'(dn_if.r_vld), 64'd0);
        check("rst_dn_w_vld", 64'(dn_if.w_vld), 64'd0);
        check("rst_up_rdy", 64'(up_if.rdy), 64'd0);
        check("rst_dn_addr", 64'(dn_if.addr), 64'd0);
        up_if.r_vld = 1'b0;
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        repeat (4) @(posedge HCLK);
        #1;
        check("post_rst_up_rdy", 64'(up_if.rdy), 64'd0);
        check("post_rst_dn_r_vld", 64'(dn_if.r_vld), 64'd0);
        dn_skip = 0;
        in_resp = 0;
    endtask

    initial begin
        int r;
        int kind;
        int lat;
        int gap;
        int stray;
        up_if.w_vld   = 1'b0;
        up_if.r_vld   = 1'b0;
        up_if.addr    = '0;
        up_if.w_data  = '0;
        up_if.byte_en = '0;
        dn_if.rdy     = 1'b0;
        dn_if.err     = 1'b0;
        dn_if.r_data  = '0;

        repeat (3) @(posedge HCLK);
        #1;
        check("reset_up_rdy", 64'(up_if.rdy), 64'd0);
        check("reset_up_err", 64'(up_if.err), 64'd0);
        check("reset_up_r_data", 64'(up_if.r_data), 64'd0);
        check("reset_dn_w_vld", 64'(dn_if.w_vld), 64'd0);
        check("reset_dn_r_vld", 64'(dn_if.r_vld), 64'd0);
        check("reset_dn_addr", 64'(dn_if.addr), 64'd0);
        check("reset_dn_w_data", 64'(dn_if.w_data), 64'd0);
        check("reset_dn_byte_en", 64'(dn_if.byte_en), 64'd0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        do_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0BADF00D, 1, 0);
        do_txn(0, 32'h20, 32'h11111111, 4'hF, 5, 1'b0, 32'h12345678, 0, 0);
        do_txn(0, 32'h30, 32'h22222222, 4'h3, 20, 1'b0, 32'hCAFEF00D, 4, 3);
        do_txn(1, 32'h40, 32'h33333333, 4'hC, 2, 1'b1, 32'h44444444, 1, 0);
        do_txn(0, 32'h44, 32'h55555555, 4'hF, TO - 1, 1'b0, 32'hA5A5A5A5, 1, 0);
        do_txn(2, 32'h50, 32'h66666666, 4'hF, 0, 1'b0, 32'h77777777, 1, 0);
        reset_mid_access();
        do_txn(0, 32'h60, 32'h0, 4'hF, 1, 1'b0, 32'h600D600D, 1, 0);

        for (int i = 0; i < 250; i++) begin
            r     = $urandom_range(0, 9);
            kind  = (r < 4) ? 0 : (r < 8) ? 1 : 2;
            lat   = $urandom_range(0, 11);
            gap   = $urandom_range(0, 3);
            stray = (gap > 1) ? $urandom_range(1, gap - 1) : 0;
            do_txn(kind, {$urandom_range(0, 255), 2'b00}, $urandom, 4'($urandom),
                   lat, 1'($urandom), $urandom, gap, stray);
        end

        up_if.w_vld = 1'b0;
        up_if.r_vld = 1'b0;
        dn_if.rdy   = 1'b0;
        repeat (6) @(posedge HCLK);
        #1;
        check("up_queue_drained", 64'(up_q.size()), 64'd0);
        check("dn_queue_drained", 64'(dn_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
